// File: rtl/pmem_arb_pkg.sv
// Shared definitions for the psum-memory arbiter: FSM encoding, core count and
// the per-core base-address helper.
package pmem_arb_pkg;

    localparam int unsigned NUM_CORES = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BURST0 = 2'd1,
        BURST1 = 2'd2
    } arb_state_e;

    // Each core owns a contiguous window of blen rows.
    function automatic int unsigned base_addr(input int unsigned core, input int unsigned blen);
        return core * blen;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker. A lone requester always wins; on a tie,
// the core that was not served last wins.
module rr_arb2
    import pmem_arb_pkg::*;
(
    input  logic [NUM_CORES-1:0] req,
    input  logic                 last_served,
    output logic [NUM_CORES-1:0] pick
);

    always_comb begin
        pick = '0;
        case (req)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = last_served ? 2'b01 : 2'b10;
            default: pick = '0;
        endcase
    end

endmodule

// File: rtl/pmem_arbiter.sv
// Arbitrates the single-port psum memory between two cores' write-back bursts
// and single-cycle host reads that slot into IDLE gaps.
module pmem_arbiter
    import pmem_arb_pkg::*;
#(
    parameter int unsigned data_bw   = 128,
    parameter int unsigned addr_bw   = 4,
    parameter int unsigned burst_len = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               req0,
    input  logic [data_bw-1:0] wdata0,
    output logic               gnt0,
    output logic               done0,
    input  logic               req1,
    input  logic [data_bw-1:0] wdata1,
    output logic               gnt1,
    output logic               done1,
    input  logic               host_rd,
    input  logic [addr_bw-1:0] host_add,
    output logic               host_gnt,
    output logic               pmem_wr,
    output logic               pmem_rd,
    output logic [addr_bw-1:0] pmem_add,
    output logic [data_bw-1:0] pmem_din
);

    localparam int unsigned     BEAT_W    = (burst_len > 1) ? $clog2(burst_len) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(burst_len - 1);

    arb_state_e           state_q, state_d;
    logic [BEAT_W-1:0]    beat_q, beat_d;
    logic                 last_served_q, last_served_d;
    logic                 host_fair_q, host_fair_d;
    logic                 pmem_wr_q, pmem_rd_q, done0_q, done1_q;
    logic [addr_bw-1:0]   pmem_add_q, pmem_add_d;
    logic [data_bw-1:0]   pmem_din_q, pmem_din_d;

    logic [NUM_CORES-1:0] pick;
    logic                 any_req, host_take, last_beat, in_burst, cur_core;

    rr_arb2 u_rr (
        .req         ({req1, req0}),
        .last_served (last_served_q),
        .pick        (pick)
    );

    assign any_req   = req0 | req1;
    assign in_burst  = (state_q == BURST0) || (state_q == BURST1);
    assign cur_core  = (state_q == BURST1);
    assign last_beat = (beat_q == LAST_BEAT);
    // A core that already waited behind one host read takes precedence.
    assign host_take = (state_q == IDLE) && host_rd && !(host_fair_q && any_req);

    assign gnt0     = (state_q == BURST0);
    assign gnt1     = (state_q == BURST1);
    assign host_gnt = host_take;

    // Next-state: grant selection in IDLE, beat counting inside a burst.
    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        last_served_d = last_served_q;
        host_fair_d   = host_fair_q;
        case (state_q)
            IDLE: begin
                if (host_take) begin
                    host_fair_d = any_req;
                end else if (pick != '0) begin
                    state_d     = pick[0] ? BURST0 : BURST1;
                    beat_d      = '0;
                    host_fair_d = 1'b0;
                end
            end
            BURST0, BURST1: begin
                if (last_beat) begin
                    beat_d        = '0;
                    state_d       = IDLE;
                    last_served_d = cur_core;
                end else begin
                    beat_d = BEAT_W'(beat_q + 1'b1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory-side address/data for the registered write and read stages.
    always_comb begin
        pmem_add_d = pmem_add_q;
        pmem_din_d = pmem_din_q;
        if (in_burst) begin
            pmem_add_d = addr_bw'(base_addr(32'(cur_core), burst_len) + 32'(beat_q));
            pmem_din_d = cur_core ? wdata1 : wdata0;
        end else if (host_take) begin
            pmem_add_d = host_add;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            beat_q        <= '0;
            last_served_q <= 1'b1;
            host_fair_q   <= 1'b0;
            pmem_wr_q     <= 1'b0;
            pmem_rd_q     <= 1'b0;
            done0_q       <= 1'b0;
            done1_q       <= 1'b0;
            pmem_add_q    <= '0;
            pmem_din_q    <= '0;
        end else begin
            state_q       <= state_d;
            beat_q        <= beat_d;
            last_served_q <= last_served_d;
            host_fair_q   <= host_fair_d;
            pmem_wr_q     <= in_burst;
            pmem_rd_q     <= host_take;
            done0_q       <= gnt0 && last_beat;
            done1_q       <= gnt1 && last_beat;
            pmem_add_q    <= pmem_add_d;
            pmem_din_q    <= pmem_din_d;
        end
    end

    assign pmem_wr  = pmem_wr_q;
    assign pmem_rd  = pmem_rd_q;
    assign done0    = done0_q;
    assign done1    = done1_q;
    assign pmem_add = pmem_add_q;
    assign pmem_din = pmem_din_q;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Scoreboard bench for pmem_arbiter: stimulus predicts whole bursts and host
// reads from the round-robin rules; a negedge monitor checks the pmem side.
module tb_pmem_arbiter;

    localparam int unsigned DBW = 128;
    localparam int unsigned ABW = 4;
    localparam int unsigned BL  = 8;

    typedef struct {
        logic [ABW-1:0] add;
        logic [DBW-1:0] din;
        logic [1:0]     done;
    } wexp_t;

    logic           clk;
    logic           reset_n;
    logic           req_v   [2];
    logic [DBW-1:0] wdata_v [2];
    logic [1:0]     gnt_w;
    logic [1:0]     done_w;
    logic           host_rd;
    logic [ABW-1:0] host_add;
    logic           host_gnt;
    logic           pmem_wr;
    logic           pmem_rd;
    logic [ABW-1:0] pmem_add;
    logic [DBW-1:0] pmem_din;

    logic [DBW-1:0] rows [2][BL];
    wexp_t          wq[$];
    logic [ABW-1:0] rq[$];
    int             checks = 0;
    int             errors = 0;
    int             host_cnt = 0;
    int             last_ms = 1;

    pmem_arbiter #(.data_bw(DBW), .addr_bw(ABW), .burst_len(BL)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req0     (req_v[0]),
        .wdata0   (wdata_v[0]),
        .gnt0     (gnt_w[0]),
        .done0    (done_w[0]),
        .req1     (req_v[1]),
        .wdata1   (wdata_v[1]),
        .gnt1     (gnt_w[1]),
        .done1    (done_w[1]),
        .host_rd  (host_rd),
        .host_add (host_add),
        .host_gnt (host_gnt),
        .pmem_wr  (pmem_wr),
        .pmem_rd  (pmem_rd),
        .pmem_add (pmem_add),
        .pmem_din (pmem_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DBW-1:0] act, input logic [DBW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every pmem access must match the head of its expectation queue.
    always @(negedge clk) begin
        if (reset_n) begin
            if (pmem_wr && pmem_rd) check("wr_rd_exclusive", 128'(1), 128'(0));
            if (host_gnt && (gnt_w != 2'b00)) check("host_gnt_in_burst", 128'(1), 128'(0));
            if (host_gnt) host_cnt++;
            if (pmem_wr) begin
                if (wq.size() == 0) begin
                    check("unexpected_write", 128'(pmem_add), 128'(0));
                end else begin
                    wexp_t e;
                    e = wq.pop_front();
                    check("wr_add", 128'(pmem_add), 128'(e.add));
                    check("wr_din", pmem_din, e.din);
                    check("wr_done", 128'(done_w), 128'(e.done));
                end
            end else if (done_w != 2'b00) begin
                check("done_without_write", 128'(done_w), 128'(0));
            end
            if (pmem_rd) begin
                if (rq.size() == 0) begin
                    check("unexpected_read", 128'(pmem_add), 128'(0));
                end else begin
                    logic [ABW-1:0] a;
                    a = rq.pop_front();
                    check("rd_add", 128'(pmem_add), 128'(a));
                end
            end
        end
    end

    // Reference: a burst of core n writes its rows to n*BL+k, done on the last.
    task automatic push_burst(input int n, input int beats);
        for (int k = 0; k < beats; k++) begin
            wexp_t e;
            e.add  = ABW'(n * BL + k);
            e.din  = rows[n][k];
            e.done = (k == BL - 1) ? 2'(1 << n) : 2'b00;
            wq.push_back(e);
        end
    endtask

    task automatic rand_rows(input int n);
        for (int k = 0; k < BL; k++) rows[n][k] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Core behaviour: present the next row each cycle, count grants, drop req on done.
    task automatic core_burst(input int n, input int drop_at, input bit host_stop);
        int beats = 0;
        bit seen  = 1'b0;
        req_v[n] = 1'b1;
        for (int t = 0; t < 400 && !seen; t++) begin
            wdata_v[n] = rows[n][(beats < BL) ? beats : BL - 1];
            @(negedge clk);
            if (done_w[n]) begin
                seen     = 1'b1;
                req_v[n] = 1'b0;
            end else if (gnt_w[n]) begin
                beats++;
                if (beats == drop_at) req_v[n] = 1'b0;
                if (host_stop && beats == BL) host_rd = 1'b0;
            end
            if (!seen) begin
                @(posedge clk);
                #1;
            end
        end
        check($sformatf("burst%0d_done_seen", n), 128'(seen), 128'(1));
        check($sformatf("burst%0d_beats", n), 128'(beats), 128'(BL));
    endtask

    task automatic host_read(input logic [ABW-1:0] a);
        host_rd  = 1'b1;
        host_add = a;
        rq.push_back(a);
        @(negedge clk);
        check("host_gnt_idle", 128'(host_gnt), 128'(1));
        @(posedge clk);
        #1;
        host_rd = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        last_ms = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic outputs_zero(input string name);
        check(name, 128'({gnt_w, done_w, host_gnt, pmem_wr, pmem_rd, pmem_add}) | pmem_din, 128'(0));
    endtask

    initial begin
        int beats;
        reset_n    = 1'b0;
        req_v[0]   = 1'b0;
        req_v[1]   = 1'b0;
        wdata_v[0] = '0;
        wdata_v[1] = '0;
        host_rd    = 1'b0;
        host_add   = '0;
        repeat (2) @(negedge clk);
        outputs_zero("reset_outputs");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Core0 alone, rows carry their beat index.
        for (int k = 0; k < BL; k++) rows[0][k] = DBW'(k);
        push_burst(0, BL);
        core_burst(0, 99, 1'b0);
        last_ms = 0;
        @(posedge clk);
        #1;

        // Both cores from reset: core0 first, then core1.
        do_reset();
        rand_rows(0);
        rand_rows(1);
        push_burst(0, BL);
        push_burst(1, BL);
        fork
            core_burst(0, 99, 1'b0);
            core_burst(1, 99, 1'b0);
        join
        last_ms = 1;
        @(posedge clk);
        #1;

        host_read(ABW'(5));

        // Host read held alongside req1: exactly one read, then the burst.
        begin
            int c0;
            rand_rows(1);
            c0       = host_cnt;
            host_rd  = 1'b1;
            host_add = ABW'(9);
            rq.push_back(ABW'(9));
            push_burst(1, BL);
            core_burst(1, 99, 1'b1);
            host_rd = 1'b0;
            @(posedge clk);
            #1;
            check("host_fair_reads", 128'(host_cnt - c0), 128'(1));
        end

        // Reset during beat 3 of core1: three writes land, then everything clears.
        rand_rows(1);
        push_burst(1, 3);
        req_v[1] = 1'b1;
        beats    = 0;
        for (int t = 0; t < 50 && beats < 4; t++) begin
            wdata_v[1] = rows[1][beats];
            @(negedge clk);
            if (gnt_w[1]) beats++;
            if (beats < 4) begin
                @(posedge clk);
                #1;
            end
        end
        check("reset_reached_beat3", 128'(beats), 128'(4));
        #2;
        reset_n = 1'b0;
        #1;
        outputs_zero("async_reset_outputs");
        req_v[1] = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        last_ms = 1;
        @(posedge clk);
        #1;
        rand_rows(1);
        push_burst(1, BL);
        core_burst(1, 99, 1'b0);
        last_ms = 1;
        @(posedge clk);
        #1;

        // Core1 drops req at beat 2; the burst still completes.
        rand_rows(1);
        push_burst(1, BL);
        core_burst(1, 2, 1'b0);
        last_ms = 1;
        @(posedge clk);
        #1;

        // Random mixes of requests and idle host reads.
        for (int it = 0; it < 24; it++) begin
            int mask;
            mask = int'($urandom_range(3, 1));
            if ($urandom_range(1, 0) == 1) host_read(ABW'($urandom_range(15, 0)));
            rand_rows(0);
            rand_rows(1);
            if (mask == 3) begin
                int first;
                first = (last_ms == 1) ? 0 : 1;
                push_burst(first, BL);
                push_burst(1 - first, BL);
                last_ms = 1 - first;
                fork
                    core_burst(0, 99, 1'b0);
                    core_burst(1, int'($urandom_range(9, 1)), 1'b0);
                join
            end else begin
                int n;
                n = (mask == 1) ? 0 : 1;
                push_burst(n, BL);
                last_ms = n;
                core_burst(n, int'($urandom_range(9, 1)), 1'b0);
            end
            @(posedge clk);
            #1;
        end

        repeat (3) @(posedge clk);
        #1;
        check("write_queue_drained", 128'(wq.size()), 128'(0));
        check("read_queue_drained", 128'(rq.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
